// File: rtl/hamming_encode_engine_if.sv
// rtl/hamming_encode_engine_if.sv - request handshake and data-memory bus of the SECDED encode engine
//
// Signals:
//   req          start pulse from the requester
//   ack          batch complete, held until the next accepted req
//   busy         high from accepted req until ack
//   mem_addr     byte address to data memory
//   mem_rd_en    read strobe, data returns on mem_rd_data one cycle later
//   mem_rd_data  sync-read data from memory
//   mem_wr_en    write strobe, byte written at the clock edge
//   mem_wr_data  write data
// Modports:
//   master  requester / memory side
//   slave   encode engine side
interface hamming_encode_engine_if #(
    parameter int ADDR_W = 8
);
    logic              req;
    logic              ack;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [7:0]        mem_rd_data;
    logic              mem_wr_en;
    logic [7:0]        mem_wr_data;

    modport master (
        output req,
        output mem_rd_data,
        input  ack,
        input  busy,
        input  mem_addr,
        input  mem_rd_en,
        input  mem_wr_en,
        input  mem_wr_data
    );

    modport slave (
        input  req,
        input  mem_rd_data,
        output ack,
        output busy,
        output mem_addr,
        output mem_rd_en,
        output mem_wr_en,
        output mem_wr_data
    );
endinterface

// File: rtl/hamming_encode_engine.sv
// rtl/hamming_encode_engine.sv - sequential SECDED Hamming(16,11) encoder over a byte-wide data memory
//
// Reads NUM_MSG 11-bit messages (lo byte = d[8:1], hi byte [2:0] = d[11:9]) starting at
// SRC_BASE, encodes each into a 16-bit codeword and writes it as a lo/hi byte pair starting
// at DST_BASE. Five cycles per message; ack is raised and held once the batch is done.
//
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset, aborts a batch immediately
//   bus      slave side of hamming_encode_engine_if (req/ack/busy + memory bus)
module hamming_encode_engine #(
    parameter int NUM_MSG  = 15,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 30,
    parameter int ADDR_W   = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    hamming_encode_engine_if.slave bus
);
    localparam int IDX_W = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_MSG - 1);
    localparam logic [ADDR_W-1:0] SRC_A    = ADDR_W'(SRC_BASE);
    localparam logic [ADDR_W-1:0] DST_A    = ADDR_W'(DST_BASE);
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_LO,
        S_RD_HI,
        S_CAPT,
        S_WR_LO,
        S_WR_HI,
        S_DONE
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [7:0]        lo_byte;
    logic [15:0]       cw_q;
    logic              ack_q;
    logic              busy_q;
    logic [ADDR_W-1:0] addr_q;
    logic              rd_en_q;
    logic              wr_en_q;
    logic [7:0]        wr_data_q;
    logic [15:0]       cw_next;

    // Codeword bit i sits at Hamming position i; p0 is the overall even parity at bit 0.
    function automatic logic [15:0] encode(input logic [11:1] d);
        logic p8, p4, p2, p1, p0;
        p8 = ^d[11:5];
        p4 = d[11] ^ d[10] ^ d[9] ^ d[8] ^ d[4] ^ d[3] ^ d[2];
        p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
        p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
        p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
        return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
    endfunction

    function automatic logic [ADDR_W-1:0] pair_addr(input logic [ADDR_W-1:0] base,
                                                     input logic [IDX_W-1:0]  i);
        return base + ADDR_W'({i, 1'b0});
    endfunction

    // Hi byte arrives on the read port during CAPT; bits [7:3] are dropped here.
    always_comb begin
        cw_next = encode({bus.mem_rd_data[2:0], lo_byte});
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            lo_byte   <= '0;
            cw_q      <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            addr_q    <= '0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
        end else begin
            // Strobes are single-cycle unless the next state re-asserts them.
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.req) begin
                        state   <= S_RD_LO;
                        idx     <= '0;
                        ack_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        addr_q  <= SRC_A;
                        rd_en_q <= 1'b1;
                    end
                end
                S_RD_LO: begin
                    state   <= S_RD_HI;
                    addr_q  <= pair_addr(SRC_A, idx) + ONE_A;
                    rd_en_q <= 1'b1;
                end
                S_RD_HI: begin
                    state   <= S_CAPT;
                    lo_byte <= bus.mem_rd_data;
                end
                S_CAPT: begin
                    state     <= S_WR_LO;
                    cw_q      <= cw_next;
                    addr_q    <= pair_addr(DST_A, idx);
                    wr_en_q   <= 1'b1;
                    wr_data_q <= cw_next[7:0];
                end
                S_WR_LO: begin
                    state     <= S_WR_HI;
                    addr_q    <= pair_addr(DST_A, idx) + ONE_A;
                    wr_en_q   <= 1'b1;
                    wr_data_q <= cw_q[15:8];
                end
                S_WR_HI: begin
                    if (idx == LAST_IDX) begin
                        state  <= S_DONE;
                        ack_q  <= 1'b1;
                        busy_q <= 1'b0;
                    end else begin
                        state   <= S_RD_LO;
                        idx     <= idx + 1'b1;
                        addr_q  <= pair_addr(SRC_A, idx + 1'b1);
                        rd_en_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack         = ack_q;
    assign bus.busy        = busy_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_rd_en   = rd_en_q;
    assign bus.mem_wr_en   = wr_en_q;
    assign bus.mem_wr_data = wr_data_q;
endmodule

// File: tb/tb_hamming_encode_engine.sv
// tb/tb_hamming_encode_engine.sv - directed self-checking bench for hamming_encode_engine
module tb_hamming_encode_engine;
    localparam int NUM_MSG  = 15;
    localparam int SRC_BASE = 0;
    localparam int DST_BASE = 30;
    localparam int ADDR_W   = 8;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    hamming_encode_engine_if #(.ADDR_W(ADDR_W)) bus ();

    hamming_encode_engine #(
        .NUM_MSG (NUM_MSG),
        .SRC_BASE(SRC_BASE),
        .DST_BASE(DST_BASE),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    logic [7:0] mem [0:255];
    logic       tb_we = 1'b0;
    logic [7:0] tb_addr = '0;
    logic [7:0] tb_data = '0;
    int         wr_count = 0;
    int         stray_wr = 0;
    int         overlap  = 0;

    always @(posedge clock) begin
        if (tb_we) mem[tb_addr] <= tb_data;
        if (bus.mem_wr_en) begin
            mem[bus.mem_addr] <= bus.mem_wr_data;
            wr_count = wr_count + 1;
            if (bus.mem_addr < 8'd30 || bus.mem_addr > 8'd59) stray_wr = stray_wr + 1;
        end
        if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
        if (bus.mem_rd_en && bus.mem_wr_en) overlap = overlap + 1;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] v);
        @(negedge clock);
        tb_we = 1'b1;
        tb_addr = a;
        tb_data = v;
        @(negedge clock);
        tb_we = 1'b0;
    endtask

    task automatic fill_dst();
        for (int a = DST_BASE; a < DST_BASE + 2 * NUM_MSG; a++) poke(8'(a), 8'hAA);
    endtask

    logic [7:0]  lo_v  [0:NUM_MSG-1];
    logic [7:0]  hi_v  [0:NUM_MSG-1];
    logic [15:0] cw_v  [0:4];

    // Pulse req and count edges, the sampling edge being edge 1, until ack is seen.
    task automatic run_batch(input int repulse_at, output int edges);
        @(negedge clock);
        bus.req = 1'b1;
        edges = 0;
        while (edges < 200) begin
            @(posedge clock);
            edges = edges + 1;
            @(negedge clock);
            bus.req = (repulse_at != 0 && edges == repulse_at) ? 1'b1 : 1'b0;
            if (bus.ack) break;
        end
        bus.req = 1'b0;
    endtask

    task automatic check_batch(input string tag);
        logic [15:0] cw;
        logic [3:0]  syn;
        logic [11:1] d_got;
        int          diffs;
        for (int i = 0; i < NUM_MSG; i++) begin
            cw = {mem[DST_BASE + 2 * i + 1], mem[DST_BASE + 2 * i]};
            if (i < 5) begin
                check_eq($sformatf("%s_cw%0d", tag, i), 32'(cw), 32'(cw_v[i]));
            end else begin
                syn = 4'd0;
                for (int b = 1; b < 16; b++) if (cw[b]) syn = syn ^ 4'(b);
                d_got = {cw[15:9], cw[7:5], cw[3]};
                check_eq($sformatf("%s_syn%0d", tag, i), 32'(syn), 32'd0);
                check_eq($sformatf("%s_par%0d", tag, i), 32'(^cw), 32'd0);
                check_eq($sformatf("%s_data%0d", tag, i), 32'(d_got), 32'({hi_v[i][2:0], lo_v[i]}));
            end
        end
        diffs = 0;
        for (int i = 0; i < NUM_MSG; i++) begin
            if (mem[SRC_BASE + 2 * i] !== lo_v[i]) diffs++;
            if (mem[SRC_BASE + 2 * i + 1] !== hi_v[i]) diffs++;
        end
        check_eq({tag, "_src_untouched"}, 32'(diffs), 32'd0);
    endtask

    initial begin
        int edges;
        int snap;
        bus.req = 1'b0;
        lo_v[0] = 8'h00; hi_v[0] = 8'h00; cw_v[0] = 16'h0000;
        lo_v[1] = 8'hFF; hi_v[1] = 8'h07; cw_v[1] = 16'hFFFF;
        lo_v[2] = 8'h01; hi_v[2] = 8'h00; cw_v[2] = 16'h000F;
        lo_v[3] = 8'h00; hi_v[3] = 8'h04; cw_v[3] = 16'h8117;
        lo_v[4] = 8'h00; hi_v[4] = 8'hFC; cw_v[4] = 16'h8117;
        for (int i = 5; i < NUM_MSG; i++) begin
            lo_v[i] = 8'($urandom_range(255));
            hi_v[i] = 8'($urandom_range(255));
        end

        repeat (2) @(posedge clock);
        @(negedge clock);
        check_eq("rst_ack", 32'(bus.ack), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
        check_eq("rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
        check_eq("rst_addr", 32'(bus.mem_addr), 32'd0);
        check_eq("rst_wr_data", 32'(bus.mem_wr_data), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < NUM_MSG; i++) begin
            poke(8'(SRC_BASE + 2 * i), lo_v[i]);
            poke(8'(SRC_BASE + 2 * i + 1), hi_v[i]);
        end
        fill_dst();

        run_batch(0, edges);
        check_eq("b1_ack_latency", 32'(edges), 32'd76);
        check_eq("b1_busy_at_ack", 32'(bus.busy), 32'd0);
        check_eq("b1_wr_count", 32'(wr_count), 32'd30);
        repeat (3) @(negedge clock);
        check_eq("b1_ack_held", 32'(bus.ack), 32'd1);
        check_batch("b1");

        fill_dst();
        run_batch(10, edges);
        check_eq("b2_repulse_latency", 32'(edges), 32'd76);
        check_batch("b2");

        fill_dst();
        @(negedge clock);
        bus.req = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.req = 1'b0;
        check_eq("rs_busy_started", 32'(bus.busy), 32'd1);
        repeat (19) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("rs_ack", 32'(bus.ack), 32'd0);
        check_eq("rs_busy", 32'(bus.busy), 32'd0);
        check_eq("rs_wr_en", 32'(bus.mem_wr_en), 32'd0);
        check_eq("rs_rd_en", 32'(bus.mem_rd_en), 32'd0);
        snap = wr_count;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(posedge clock);
        @(negedge clock);
        check_eq("rs_no_writes", 32'(wr_count), 32'(snap));
        check_eq("rs_idle_busy", 32'(bus.busy), 32'd0);

        fill_dst();
        run_batch(0, edges);
        check_eq("b3_ack_latency", 32'(edges), 32'd76);
        check_batch("b3");

        check_eq("stray_writes", 32'(stray_wr), 32'd0);
        check_eq("rd_wr_overlap", 32'(overlap), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
